// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and helpers for the memory port arbiter.
package mem_arb_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [31:0] DEF_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] DEF_MEM_DEPTH_BYTES = 32'h0010_0000;

  // Replace the byte lanes selected by be with the matching lanes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = word;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
    return r;
  endfunction

  // Range test done in 33 bits so base+depth cannot wrap.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [32:0] lo, hi, a;
    lo = {1'b0, base};
    hi = lo + {1'b0, depth};
    a  = {1'b0, addr};
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/arb_prio_fair.sv
// P1-priority arbiter with a starvation guard that forces P0 through after
// MAX_WAIT consecutive losses.
module arb_prio_fair #(
  parameter int MAX_WAIT = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic p0_req,
  input  logic p1_req,
  output logic sel_p0,
  output logic sel_p1
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;
  logic          starved;

  assign starved = (wait_cnt >= WW'(MAX_WAIT));

  // P1 wins ties unless P0 has waited long enough.
  always_comb begin
    sel_p1 = en && p1_req && !(p0_req && starved);
    sel_p0 = en && p0_req && !sel_p1;
  end

  // Count consecutive cycles P0 asks and loses; saturate at MAX_WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (p0_req && !sel_p0) begin
      if (!starved) wait_cnt <= wait_cnt + 1'b1;
    end else
      wait_cnt <= '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port word memory between fetch (P0) and load/store (P1).
// Sub-word stores become a read cycle followed by a merged write cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEF_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES,
  parameter int          MAX_WAIT        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  state_t      state, state_nxt;
  logic        sel_p0, sel_p1;
  logic        p0_ok, p1_ok, p1_partial;
  logic        rd_p0, rd_p1, acc_err, rmw_start;
  logic [31:0] rmw_word, last_addr, last_din;

  assign p0_ok      = in_range(p0_addr, STARTING_ADDR, MEM_DEPTH_BYTES);
  assign p1_ok      = in_range(p1_addr, STARTING_ADDR, MEM_DEPTH_BYTES);
  // Out-of-range partial stores are rejected in one cycle, no RMW.
  assign p1_partial = p1_we && p1_ok && (p1_be != 4'b0000) && (p1_be != 4'b1111);

  arb_prio_fair #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (reset_n && (state == IDLE)),
    .p0_req (p0_req),
    .p1_req (p1_req),
    .sel_p0 (sel_p0),
    .sel_p1 (sel_p1)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: a partial store detours through RMW_WR for its write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (sel_p1 && p1_partial) state_nxt = RMW_WR;
      RMW_WR: state_nxt = IDLE;
    endcase
  end

  // Memory drive and grants; everything is quiet while reset is held.
  always_comb begin
    p0_gnt         = 1'b0;
    p1_gnt         = 1'b0;
    mem_address    = last_addr;
    mem_data_in    = last_din;
    mem_read_write = READ;
    rd_p0          = 1'b0;
    rd_p1          = 1'b0;
    acc_err        = 1'b0;
    rmw_start      = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (sel_p0) begin
            p0_gnt      = 1'b1;
            rd_p0       = 1'b1;
            acc_err     = !p0_ok;
            mem_address = word_addr(p0_addr);
          end else if (sel_p1) begin
            mem_address = word_addr(p1_addr);
            if (p1_partial)
              rmw_start = 1'b1;
            else begin
              p1_gnt  = 1'b1;
              acc_err = !p1_ok;
              rd_p1   = !p1_we;
              if (p1_we && p1_ok && (p1_be == 4'b1111)) begin
                mem_read_write = WRITE;
                mem_data_in    = p1_wdata;
              end
            end
          end
        end
        RMW_WR: begin
          p1_gnt         = 1'b1;
          mem_address    = word_addr(p1_addr);
          mem_read_write = WRITE;
          mem_data_in    = merge_bytes(rmw_word, p1_wdata, p1_be);
        end
      endcase
    end
  end

  // Registered read data, pulses, RMW word capture and held memory drive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rmw_word  <= '0;
      last_addr <= STARTING_ADDR;
      last_din  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      last_addr <= mem_address;
      last_din  <= mem_data_in;
      p0_rvalid <= rd_p0;
      p1_rvalid <= rd_p1;
      err       <= acc_err;
      if (rmw_start) rmw_word <= mem_data_out;
      if (rd_p0)     p0_rdata <= p0_ok ? mem_data_out : '0;
      if (rd_p1)     p1_rdata <= p1_ok ? mem_data_out : '0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, word-wide main memory between an instruction-fetch port (P0) and a load/store port (P1).
- Sequences each access onto the memory's address / data_in / read_write / data_out interface and registers the read data returned to the requester.
- Sub-word stores are done as a two-cycle read-modify-write (RMW), because the memory only writes whole words.
- Sits between the core's fetch/LSU stages and the main memory.

Parameters:
- STARTING_ADDR, 'h01000000, byte address of memory byte 0.
- MEM_DEPTH_BYTES, 'h0100000, memory size; the legal range is [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES).
- MAX_WAIT, 3, number of consecutive cycles P0 may lose arbitration before it is forced to win.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  fetch request; held until p0_gnt.
- p0_addr  in  32  fetch byte address; bits [1:0] ignored.
- p0_gnt  out  1  access accepted this cycle (combinational).
- p0_rvalid  out  1  p0_rdata valid; one-cycle pulse.
- p0_rdata  out  32  fetched word.
- p1_req  in  1  load/store request; held until p1_gnt.
- p1_we  in  1  1 = store, 0 = load.
- p1_addr  in  32  byte address; bits [1:0] ignored.
- p1_wdata  in  32  store data, lane-aligned.
- p1_be  in  4  byte enables; be[k] selects bits [8k+7:8k].
- p1_gnt  out  1  access accepted this cycle (combinational).
- p1_rvalid  out  1  p1_rdata valid; one-cycle pulse (loads only).
- p1_rdata  out  32  loaded word.
- err  out  1  one-cycle pulse: the granted address was out of range.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory data_in.
- mem_data_out  in  32  from memory data_out (combinational read).
- mem_read_write  out  1  0 = READ, 1 = WRITE (sampled by memory at posedge).

Behaviour:
- Reset (async assert): state=IDLE, wait_cnt=0, rmw_word=0, all rvalid=0, err=0, rdata=0, mem_read_write=READ, mem_address=STARTING_ADDR, mem_data_in=0.
- Deassertion takes effect at the next posedge. Reset during RMW_WR aborts the store; no memory write occurs.
- States: IDLE, RMW_WR.
- Arbitration in IDLE:
  - P1 wins when both request, unless wait_cnt==MAX_WAIT, in which case P0 wins.
  - wait_cnt increments each cycle P0 requests and loses; it clears when P0 is granted or p0_req=0.
  - At most one gnt per cycle; gnt is never asserted in the same cycle as reset_n=0.
- Read access (P0, or P1 with we=0), one cycle in IDLE:
  - mem_address = {addr[31:2],2'b00}, READ, gnt=1.
  - mem_data_out is registered into rdata at that posedge; rvalid=1 in the following cycle.
  - Back-to-back reads give one word per cycle.
- Full-word store (be=4'b1111): one cycle, mem_read_write=WRITE, mem_data_in=p1_wdata, p1_gnt=1, no rvalid.
- Partial store (be not 1111 and not 0000):
  - Cycle 1 (IDLE): READ of the word; latch into rmw_word; no gnt; go to RMW_WR.
  - Cycle 2 (RMW_WR): WRITE of (rmw_word with enabled lanes replaced from p1_wdata); p1_gnt=1; return to IDLE.
  - P0 is blocked during RMW_WR and wait_cnt keeps counting.
- be=4'b0000 store: one cycle, p1_gnt=1, memory stays READ (no-op).
- Out-of-range address:
  - gnt=1 and err=1 in the following cycle.
  - No memory write; rdata=0; rvalid still pulses for reads.
- Idle cycles (no request): READ, mem_address holds its last value.
- Requester changes addr/we while req is held without gnt: undefined; the bench flags it as a protocol violation.

Decomposition:
- Package mem_arb_pkg holds:
  - READ/WRITE constants;
  - state encoding IDLE/RMW_WR;
  - STARTING_ADDR and MEM_DEPTH_BYTES defaults;
  - function merge_bytes(word, wdata, be).
- One sub-module, arb_prio_fair: P1-priority arbitration plus the wait_cnt starvation guard, producing sel_p0/sel_p1.

Test Plan:
- P0 fetch alone at 01000000 then 01000004, memory preloaded with 00000013 and 00a00093 -> p0_gnt in 2 consecutive cycles; p0_rvalid on the next 2 cycles with rdata 00000013 then 00a00093.
- P1 store be=1111, addr 01000010, wdata deadbeef; then P1 load of 01000010 -> store takes 1 cycle; load returns deadbeef.
- Word 11223344 at 01000020; P1 store be=0010, wdata 0000aa00 -> RMW: p1_gnt only in the 2nd cycle; a subsequent load returns 1122aa44.
- P0 and P1 request continuously, MAX_WAIT=3 -> P1 wins 3 cycles, P0 wins the 4th; the pattern repeats; no gnt overlap.
- P1 load at 00fffffc and store at 01100000 -> gnt=1; err pulses next cycle; rdata=0; memory unchanged.
- reset_n pulsed low during RMW_WR of be=0001 to 01000030 (old 55667788) -> no write; outputs at reset values; a later load returns 55667788.
